// File: rtl/stage_memory.sv
`default_nettype none
// ============================================================================
// Module   : stage_memory
// Brief    : Pipeline memory stage: data-memory port, W->M store bypass,
//            M/W latch and stall-safe alignment of synchronous load data.
// Revision : 1.0
// ============================================================================
module stage_memory #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              valid_x,
    input  logic [4:0]        opcode_x,
    input  logic [4:0]        alu_op_x,
    input  logic [4:0]        rd_x,
    input  logic [31:0]       alu_result_x,
    input  logic [31:0]       store_data_x,
    input  logic [31:0]       pc_plus_4_x,
    input  logic [26:0]       target_x,
    input  logic              exception_x,
    input  logic [31:0]       data_writeReg_w,
    input  logic [4:0]        ctrl_writeReg_w,
    input  logic              ctrl_writeEnable_w,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [31:0]       data_dmem,
    output logic              wren_dmem,
    input  logic [31:0]       q_dmem,
    output logic [4:0]        opcode_w,
    output logic [4:0]        alu_op_w,
    output logic [4:0]        rd_w,
    output logic [4:0]        pc_upper_5_w,
    output logic [31:0]       alu_result_w,
    output logic [31:0]       pc_plus_4_w,
    output logic [26:0]       target_w,
    output logic              exception_w,
    output logic              valid_w,
    output logic [31:0]       q_dmem_w
);

    localparam logic [4:0] c_OP_SW = 5'b00111;

    logic w_is_sw;
    logic w_bypass;

    // M/W latch state
    logic [4:0]  opcode_q,     opcode_d;
    logic [4:0]  alu_op_q,     alu_op_d;
    logic [4:0]  rd_q,         rd_d;
    logic [4:0]  pc_upper_5_q, pc_upper_5_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] pc_plus_4_q,  pc_plus_4_d;
    logic [26:0] target_q,     target_d;
    logic        exception_q,  exception_d;
    logic        valid_q,      valid_d;

    // Load-data hold state
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] q_hold_q,     q_hold_d;

    assign w_is_sw  = (opcode_x == c_OP_SW);
    assign w_bypass = w_is_sw & valid_x & ctrl_writeEnable_w
                    & (ctrl_writeReg_w != 5'd0) & (ctrl_writeReg_w == rd_x);

    assign address_dmem = alu_result_x[ADDR_W-1:0];
    assign data_dmem    = w_bypass ? data_writeReg_w : store_data_x;
    assign wren_dmem    = w_is_sw & valid_x & ~stall;

    always_comb begin
        opcode_d     = opcode_q;
        alu_op_d     = alu_op_q;
        rd_d         = rd_q;
        pc_upper_5_d = pc_upper_5_q;
        alu_result_d = alu_result_q;
        pc_plus_4_d  = pc_plus_4_q;
        target_d     = target_q;
        exception_d  = exception_q;
        valid_d      = valid_q;
        if (!stall) begin
            if (valid_x) begin
                opcode_d     = opcode_x;
                alu_op_d     = alu_op_x;
                rd_d         = rd_x;
                pc_upper_5_d = pc_plus_4_x[31:27];
                alu_result_d = alu_result_x;
                pc_plus_4_d  = pc_plus_4_x;
                target_d     = target_x;
                exception_d  = exception_x;
                valid_d      = 1'b1;
            end else begin
                opcode_d     = 5'd0;
                alu_op_d     = 5'd0;
                rd_d         = 5'd0;
                pc_upper_5_d = 5'd0;
                alu_result_d = 32'd0;
                pc_plus_4_d  = 32'd0;
                target_d     = 27'd0;
                exception_d  = 1'b0;
                valid_d      = 1'b0;
            end
        end
    end

    // q_dmem follows M's address, so capture W's load data on the first stall edge.
    always_comb begin
        hold_valid_d = hold_valid_q;
        q_hold_d     = q_hold_q;
        if (stall) begin
            if (!hold_valid_q) begin
                q_hold_d     = q_dmem;
                hold_valid_d = 1'b1;
            end
        end else begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_q     <= 5'd0;
            alu_op_q     <= 5'd0;
            rd_q         <= 5'd0;
            pc_upper_5_q <= 5'd0;
            alu_result_q <= 32'd0;
            pc_plus_4_q  <= 32'd0;
            target_q     <= 27'd0;
            exception_q  <= 1'b0;
            valid_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            q_hold_q     <= 32'd0;
        end else begin
            opcode_q     <= opcode_d;
            alu_op_q     <= alu_op_d;
            rd_q         <= rd_d;
            pc_upper_5_q <= pc_upper_5_d;
            alu_result_q <= alu_result_d;
            pc_plus_4_q  <= pc_plus_4_d;
            target_q     <= target_d;
            exception_q  <= exception_d;
            valid_q      <= valid_d;
            hold_valid_q <= hold_valid_d;
            q_hold_q     <= q_hold_d;
        end
    end

    assign opcode_w     = opcode_q;
    assign alu_op_w     = alu_op_q;
    assign rd_w         = rd_q;
    assign pc_upper_5_w = pc_upper_5_q;
    assign alu_result_w = alu_result_q;
    assign pc_plus_4_w  = pc_plus_4_q;
    assign target_w     = target_q;
    assign exception_w  = exception_q;
    assign valid_w      = valid_q;
    assign q_dmem_w     = hold_valid_q ? q_hold_q : q_dmem;

endmodule
`default_nettype wire

// File: doc/stage_memory.md
# stage_memory

Memory stage of the five-stage pipeline, between the execute/memory (X/M) latch and the write stage. It drives the data-memory port for `lw`/`sw`. It bypasses store data from the write stage. It owns the memory/writeback (M/W) pipeline latch. It keeps the synchronous-read `q_dmem` value aligned with the instruction in W across stalls.

## Interface
Parameters:
- `ADDR_W`, 12: data-memory word-address width.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `stall` in 1: from the hazard unit; holds the M/W latch and the instruction in M.
- `valid_x` in 1: the X/M latch holds a real instruction (0 = bubble).
- `opcode_x`, `alu_op_x`, `rd_x` in 5 each: fields from the X/M latch.
- `alu_result_x` in 32: ALU result; this is the effective address for `lw`/`sw`.
- `store_data_x` in 32: value of `$rd` read in decode; this is the store data.
- `pc_plus_4_x` in 32: PC+4 of the instruction.
- `target_x` in 27: J-type target field.
- `exception_x` in 1: overflow/exception flag from the ALU or mult/div.
- `data_writeReg_w` in 32, `ctrl_writeReg_w` in 5, `ctrl_writeEnable_w` in 1: the write-stage result, used for bypass.
- `address_dmem` out ADDR_W: `alu_result_x[ADDR_W-1:0]`.
- `data_dmem` out 32: store data after bypass.
- `wren_dmem` out 1: data-memory write enable.
- `q_dmem` in 32: data-memory read data; valid one cycle after its address is presented.
- `opcode_w`, `alu_op_w`, `rd_w`, `pc_upper_5_w` out 5 each: M/W latch fields.
- `alu_result_w`, `pc_plus_4_w` out 32: M/W latch fields.
- `target_w` out 27: M/W latch field.
- `exception_w`, `valid_w` out 1: M/W latch fields.
- `q_dmem_w` out 32: load data aligned to the instruction in W.

## Operation
- Decode:
  - `sw` = `opcode_x`==00111.
  - `lw` = `opcode_x`==01000.
- `wren_dmem` = `sw & valid_x & ~stall`. It is combinational. One write is made per store, on the cycle the store leaves M.
- `address_dmem` is driven every cycle regardless of opcode. Reads are harmless.
- Store-data bypass (W→M):
  - When `sw & valid_x & ctrl_writeEnable_w & (ctrl_writeReg_w != 0) & (ctrl_writeReg_w == rd_x)`, then `data_dmem` = `data_writeReg_w`.
  - Otherwise `data_dmem` = `store_data_x`.
- M/W latch:
  - Loads on each rising edge with `stall`=0.
  - When `valid_x`=1, it captures `opcode_x`, `alu_op_x`, `rd_x`, `alu_result_x`, `pc_plus_4_x`, `target_x`, `exception_x`, and sets `pc_upper_5_w` = `pc_plus_4_x[31:27]` and `valid_w`=1.
  - When `valid_x`=0, it loads a bubble: all fields 0 and `valid_w`=0. Opcode 00000 with rd 0 writes `$r0`, which is ignored.
  - With `stall`=1, all latch fields hold.
- Load-data hold register. This exists because `q_dmem` follows whatever address M presents, so a stall would otherwise corrupt W's load data.
  - State: `hold_valid` (1 bit) and `q_hold` (32 bits).
  - Edge with `stall`=1 and `hold_valid`=0: `q_hold` <= `q_dmem`, `hold_valid` <= 1.
  - Edge with `stall`=1 and `hold_valid`=1: both hold.
  - Edge with `stall`=0: `hold_valid` <= 0.
  - `q_dmem_w` = `hold_valid ? q_hold : q_dmem`.

## Timing
- Reset (asynchronous, immediate): every M/W field is 0, `valid_w`=0, `hold_valid`=0, `q_hold`=0.
  - `q_dmem_w` therefore equals `q_dmem` after reset.
  - `wren_dmem` follows its combinational equation. Upstream bubbles keep it at 0.
- Latency:
  - Instruction fields: X/M→M/W is one cycle.
  - Load: address presented in cycle t; `q_dmem_w` valid in cycle t+1 with the load in W.
- Multi-cycle stall: `q_dmem_w` stays at the value captured on the first stall edge until the edge that ends the stall.
- Stall deasserted: the M/W latch advances on the same edge that clears `hold_valid`.
  - The next cycle shows raw `q_dmem` for the new W instruction.
- Store held by a stall: no write while stalled; exactly one write on the releasing cycle.
- Bypass and stall together: the bypass is evaluated each cycle against the current W contents. W is frozen, so the selected data is stable.
- Reset mid-stall: `hold_valid` clears immediately; the latch becomes a bubble.
- No combinational path from `q_dmem` to any registered output other than through `q_hold`.

## Test plan
1. Reset asserted mid-stream:
   - All `*_w` outputs are 0.
   - `valid_w`=0.
   - `q_dmem_w`==`q_dmem`.
2. Store then load at address 5:
   - Stimulus: `sw` with `alu_result_x`=5, `store_data_x`=0xDEADBEEF, then `lw` with address 5.
   - Response: `wren_dmem`=1 for exactly one cycle with `address_dmem`=5.
   - Next cycle `q_dmem_w`=0xDEADBEEF with `opcode_w`=01000.
3. Bypass:
   - Stimulus: W writes `$r3` with 0x1234 (`ctrl_writeEnable_w`=1) while `sw` with `rd_x`=3, `store_data_x`=0.
   - Response: `data_dmem`=0x1234.
   - Repeat with `ctrl_writeReg_w`=0: `data_dmem`=`store_data_x`.
4. Stall with a load in W:
   - Stimulus: `lw` returns 0xAAAA5555; `stall`=1 for 3 cycles while M presents an address holding 0x0.
   - Response: `q_dmem_w` stays 0xAAAA5555 for all 3 cycles.
   - After release, the M/W latch advances and `q_dmem_w` tracks raw `q_dmem`.
5. Store under stall:
   - Stimulus: `sw` in M, `stall`=1 for 2 cycles.
   - Response: `wren_dmem`=0 during the stall; 1 only on the release cycle.
6. Bubble:
   - Stimulus: `valid_x`=0 with a nonzero `opcode_x`/`rd_x`.
   - Response: next cycle `opcode_w`=0, `rd_w`=0, `valid_w`=0, `wren_dmem` stays 0.
